// File: rtl/image_stream_ctrl.sv
// image_stream_ctrl: loads a binary image into the image memory, then streams it
// out one pixel at a time over a valid/ready handshake.
`default_nettype none

module image_stream_ctrl #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_PIXELS-1:0] pixel_in,
   output logic                  mem_reset,
   output logic                  mem_init,
   output logic [NUM_PIXELS-1:0] mem_pixel_data,
   output logic [ADDR_W-1:0]     mem_address,
   input  logic [31:0]           mem_data_out,
   input  logic                  mem_done,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [31:0]           pix_data,
   output logic [9:0]            pix_index,
   output logic                  pix_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLR     = 3'd1,
      S_LOAD    = 3'd2,
      S_FETCH   = 3'd3,
      S_CAPTURE = 3'd4,
      S_PRESENT = 3'd5,
      S_FINISH  = 3'd6
   } state_t;

   localparam logic [9:0] LAST_K = 10'(NUM_PIXELS - 1);

   state_t                state_q, state_d;
   logic [9:0]            k_q, k_d;
   logic [NUM_PIXELS-1:0] img_q, img_d;
   logic [31:0]           data_q, data_d;
   logic [9:0]            idx_q, idx_d;
   logic                  last_q, last_d;
   logic                  mem_reset_q, mem_init_q, pix_valid_q, busy_q, done_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      img_d   = img_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               img_d   = pixel_in;
               k_d     = 10'd0;
               state_d = S_CLR;
            end
         end
         S_CLR:     state_d = S_LOAD;
         S_LOAD:    if (mem_done) state_d = S_FETCH;
         S_FETCH:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            data_d  = mem_data_out;
            idx_d   = k_q;
            last_d  = (k_q == LAST_K);
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (pix_ready) begin
               if (k_q == LAST_K) begin
                  state_d = S_FINISH;
               end else begin
                  k_d     = k_q + 10'd1;
                  state_d = S_FETCH;
               end
            end
         end
         S_FINISH:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // Abort wins over everything, including a handshake in the same cycle.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         k_d     = k_q;
      end
   end

   // Status outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         k_q         <= 10'd0;
         img_q       <= '0;
         data_q      <= 32'd0;
         idx_q       <= 10'd0;
         last_q      <= 1'b0;
         mem_reset_q <= 1'b0;
         mem_init_q  <= 1'b0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         img_q       <= img_d;
         data_q      <= data_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         mem_reset_q <= (state_d == S_CLR);
         mem_init_q  <= (state_d == S_LOAD);
         pix_valid_q <= (state_d == S_PRESENT);
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_FINISH);
      end
   end

   assign mem_reset      = mem_reset_q;
   assign mem_init       = mem_init_q;
   assign mem_pixel_data = img_q;
   assign mem_address    = ADDR_W'(k_q);
   assign pix_valid      = pix_valid_q;
   assign pix_data       = data_q;
   assign pix_index      = idx_q;
   assign pix_last       = last_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_image_stream_ctrl.sv
// tb_image_stream_ctrl: randomized stimulus against a transaction-level model of
// the load-then-stream behaviour, with a simple image-memory model attached.
`default_nettype none

module tb_image_stream_ctrl;

   localparam int NP = 784;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NP-1:0] pixel_in = '0;
   logic          mem_reset, mem_init;
   logic [NP-1:0] mem_pixel_data;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_data_out = 32'd0;
   logic          mem_done = 1'b0;
   logic          pix_valid;
   logic          pix_ready = 1'b1;
   logic [31:0]   pix_data;
   logic [9:0]    pix_index;
   logic          pix_last, busy, done;

   int checks = 0;
   int failures = 0;

   image_stream_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .pixel_in(pixel_in),
      .mem_reset(mem_reset), .mem_init(mem_init), .mem_pixel_data(mem_pixel_data),
      .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_done(mem_done),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_index(pix_index), .pix_last(pix_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Image memory: cleared by mem_reset, captures the image mem_lat cycles into a load.
   logic [NP-1:0] mem_img = '0;
   int            init_cnt = 0;
   int            mem_lat = 1;
   always @(posedge clk) begin
      if (mem_reset) mem_img <= '0;
      if (!mem_init) begin
         init_cnt <= 0;
         mem_done <= 1'b0;
      end else begin
         init_cnt <= init_cnt + 1;
         if (init_cnt >= mem_lat) begin
            mem_done <= 1'b1;
            mem_img  <= mem_pixel_data;
         end
      end
      mem_data_out <= (int'(mem_address) < NP) ? {31'd0, mem_img[mem_address]} : 32'd0;
   end

   // Transaction-level model state
   logic          m_act = 0, m_done = 0, m_mrst = 0, m_init = 0, m_after_beat = 0, m_stall = 0;
   logic [NP-1:0] m_img = '0;
   int            m_idx = 0;
   logic [31:0]   sv_data;
   logic [9:0]    sv_idx;
   logic          sv_last;
   int            beats = 0, ones = 0, done_cnt = 0, cyc = 0;
   int            first_beat_cyc = 0, last_beat_cyc = 0;
   logic          got [NP];
   logic          acc, beat, nd, n_init, n_act;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         chk("reset_outputs", {54'd0, mem_reset, mem_init, pix_valid, pix_last, busy, done,
             |mem_address, |pix_data, |pix_index, |mem_pixel_data}, 64'd0);
         m_act = 0; m_done = 0; m_mrst = 0; m_init = 0; m_after_beat = 0; m_stall = 0;
         m_img = '0; m_idx = 0;
      end else begin
         chk("busy", busy, m_act);
         chk("done", done, m_done);
         chk("mem_reset", mem_reset, m_mrst);
         chk("mem_init", mem_init, m_init);
         chk("mem_pixel_data_match", mem_pixel_data === m_img, 1);
         if (!m_act || m_after_beat) chk("pix_valid_low", pix_valid, 0);
         if (m_stall) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, sv_data);
            chk("stall_index", pix_index, sv_idx);
            chk("stall_last", pix_last, sv_last);
         end
         if (pix_valid) chk("addr_eq_index", mem_address, AW'(pix_index));
         if (done) done_cnt++;

         acc  = !m_act && start;
         beat = m_act && pix_valid && pix_ready && !abort;
         nd   = 0;
         if (beat) begin
            chk("beat_index", pix_index, m_idx);
            chk("beat_data", pix_data, {31'd0, m_img[m_idx]});
            chk("beat_last", pix_last, (m_idx == NP - 1));
            got[m_idx] = pix_data[0];
            beats++;
            if (pix_data == 32'd1) ones++;
            if (beats == 1) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (m_idx == NP - 1) nd = 1;
            else m_idx++;
         end
         n_init = (m_act && abort) ? 1'b0 : m_mrst ? 1'b1 : (m_init && mem_done) ? 1'b0 : m_init;
         n_act  = acc ? 1'b1 : (m_act && (abort || m_done)) ? 1'b0 : m_act;
         m_stall = m_act && pix_valid && !pix_ready && !abort;
         sv_data = pix_data; sv_idx = pix_index; sv_last = pix_last;
         m_after_beat = beat;
         m_mrst = acc;
         m_init = n_init;
         m_done = nd;
         m_act  = n_act;
         if (acc) begin
            m_img = pixel_in; m_idx = 0; beats = 0; ones = 0;
         end
      end
   end

   int rdy_pct = 100;
   initial begin
      forever begin
         @(posedge clk); #1;
         pix_ready = ($urandom_range(0, 99) < rdy_pct);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [NP-1:0] img);
      start = 1'b1; pixel_in = img;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin tick(); n++; end
      chk("done_within_budget", n < budget, 1);
   endtask

   task automatic wait_idx(input int idx, input int budget);
      int n = 0;
      while (!(pix_valid && int'(pix_index) == idx) && n < budget) begin tick(); n++; end
      chk("reach_index_within_budget", n < budget, 1);
   endtask

   task automatic wait_init(input int budget);
      int n = 0;
      while (!mem_init && n < budget) begin tick(); n++; end
      chk("reach_load_within_budget", n < budget, 1);
   endtask

   function automatic logic [NP-1:0] rand_img();
      logic [NP-1:0] v;
      for (int i = 0; i < NP; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   logic [NP-1:0] img_a, img_b;
   int            dc0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_addr", mem_address, 0);
      chk("reset_pix_data", pix_data, 0);
      chk("reset_img_zero", mem_pixel_data === '0, 1);
      tick(); reset = 1'b1; tick();

      // Sparse image, ready always high
      img_a = '0; img_a[0] = 1'b1; img_a[5] = 1'b1; img_a[783] = 1'b1;
      dc0 = done_cnt;
      do_start(img_a);
      wait_done(4000);
      tick();
      chk("A_beats", beats, 784);
      chk("A_ones", ones, 3);
      chk("A_got0", got[0], 1);
      chk("A_got5", got[5], 1);
      chk("A_got6", got[6], 0);
      chk("A_got783", got[783], 1);
      chk("A_span", last_beat_cyc - first_beat_cyc, 2349);
      chk("A_done_count", done_cnt - dc0, 1);

      // Random image, 30% ready
      rdy_pct = 30; mem_lat = 3;
      do_start(rand_img());
      wait_done(20000);
      tick();
      chk("B_beats", beats, 784);
      rdy_pct = 100;

      // Second start during LOAD is ignored
      img_a = rand_img(); img_b = ~img_a;
      do_start(img_a);
      wait_init(20);
      start = 1'b1; pixel_in = img_b; tick(); start = 1'b0;
      chk("C_image_kept", mem_pixel_data === img_a, 1);
      wait_done(4000);
      tick();
      chk("C_beats", beats, 784);

      // Abort at pixel 100, then a full re-stream
      mem_lat = 0;
      dc0 = done_cnt;
      do_start(rand_img());
      wait_idx(100, 1000);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("D_busy_after_abort", busy, 0);
      chk("D_valid_after_abort", pix_valid, 0);
      repeat (3) tick();
      chk("D_no_done", done_cnt - dc0, 0);
      do_start(rand_img());
      wait_done(4000);
      tick();
      chk("D_beats", beats, 784);

      // Reset in the middle of PRESENT
      do_start(rand_img());
      wait_idx(50, 1000);
      #2 reset = 1'b0;
      #1;
      chk("E_async_zero", {mem_reset, mem_init, pix_valid, pix_last, busy, done,
          |mem_address, |pix_data, |pix_index, |mem_pixel_data}, 10'd0);
      tick(); reset = 1'b1; tick();
      do_start(rand_img());
      wait_done(4000);
      tick();
      chk("E_beats", beats, 784);

      // Abort coincident with the last-pixel handshake
      dc0 = done_cnt;
      do_start(rand_img());
      wait_idx(783, 4000);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("F_busy", busy, 0);
      chk("F_done", done, 0);
      repeat (2) tick();
      chk("F_no_done", done_cnt - dc0, 0);

      // Abort together with start in IDLE acts as start
      abort = 1'b1; do_start(rand_img()); abort = 1'b0;
      chk("G_busy", busy, 1);
      wait_done(4000);
      tick();
      chk("G_beats", beats, 784);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
